// File: rtl/fir_coef_loader.sv
// fir_coef_loader
//   Write side of the FIR coefficient RAM read by micFilter over fir_memory_s2.
//   Loads a (base, count) block from a valid/ready word stream into RAM port s1,
//   one word per clock, and reports busy/done/aborted status to the control logic.
//
//   Build option: define FIR_LOADER_VERIFY_EN to read the loaded range back after
//   the write pass and compare its checksum with the sum of the accepted words.
//
//   state  | meaning
//   IDLE   | waiting for cmd_start
//   WRITE  | accepting stream words, one RAM write per accepted word
//   VERIFY | reading the loaded range back and summing the returned words
//   FINISH | load complete; done pulses on the following cycle
module fir_coef_loader #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_start,
    input  logic                cmd_abort,
    input  logic [ADDR_W-1:0]   cmd_base,
    input  logic [ADDR_W:0]     cmd_count,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [ADDR_W-1:0]   s1_address,
    output logic                s1_chipselect,
    output logic                s1_write,
    output logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W/8-1:0] s1_byteenable,
    output logic                s1_clken,
    input  logic [DATA_W-1:0]   s1_readdata,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                verify_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

`ifdef FIR_LOADER_VERIFY_EN
    localparam state_t AFTER_WRITE = VERIFY;
`else
    localparam state_t AFTER_WRITE = FINISH;
`endif

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     idx_q;
    logic                done_q;
    logic                aborted_q;
    logic                cs_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                busy_int;
    logic                start_ok;
    logic                abort_ok;
    logic                accept;
    logic                last_accept;

    // done is registered, so the unit still reports busy in the done cycle;
    // a new start is only taken once both have dropped.
    assign busy_int    = (state != IDLE) || done_q;
    assign start_ok    = cmd_start && !busy_int;
    assign abort_ok    = cmd_abort && (state != IDLE);
    assign in_ready    = (state == WRITE);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (idx_q == count_q - CNT_ONE);

`ifdef FIR_LOADER_VERIFY_EN
    logic [DATA_W-1:0]   wsum_q;
    logic [DATA_W-1:0]   rsum_q;
    logic [ADDR_W:0]     ridx_q;
    logic [ADDR_W:0]     rcnt_q;
    logic [RD_LAT-1:0]   rd_pipe_q;
    logic                verr_q;
    logic                rd_req;
    logic                rd_issue;
    logic                rd_ret;
    logic                last_ret;

    assign rd_req   = (state == VERIFY) && (ridx_q != count_q) && !cmd_abort;
    assign rd_issue = cs_q && !we_q;
    assign rd_ret   = rd_pipe_q[RD_LAT-1] && (state == VERIFY) && !cmd_abort;
    assign last_ret = rd_ret && (rcnt_q == count_q - CNT_ONE);

    // checksums of written and read-back words, read issue/return tracking
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            wsum_q    <= '0;
            rsum_q    <= '0;
            ridx_q    <= '0;
            rcnt_q    <= '0;
            rd_pipe_q <= '0;
            verr_q    <= 1'b0;
        end else begin
            if (accept) begin
                wsum_q <= wsum_q + in_data;
            end
            if (rd_req) begin
                ridx_q <= ridx_q + CNT_ONE;
            end
            rd_pipe_q <= (rd_pipe_q << 1) | RD_LAT'(rd_issue);
            if (rd_ret) begin
                rsum_q <= rsum_q + s1_readdata;
                rcnt_q <= rcnt_q + CNT_ONE;
                if (last_ret) begin
                    verr_q <= (rsum_q + s1_readdata) != wsum_q;
                end
            end
        end
    end

    assign verify_err = verr_q;
`else
    logic unused_rdata;
    localparam int unused_rd_lat = RD_LAT;

    assign unused_rdata = ^s1_readdata;
    assign verify_err   = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    next_state = (cmd_count == '0) ? FINISH : WRITE;
                end
            end
            WRITE: begin
                if (abort_ok) begin
                    next_state = IDLE;
                end else if (last_accept) begin
                    next_state = AFTER_WRITE;
                end
            end
`ifdef FIR_LOADER_VERIFY_EN
            VERIFY: begin
                if (abort_ok) begin
                    next_state = IDLE;
                end else if (last_ret) begin
                    next_state = FINISH;
                end
            end
`endif
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // command latch, word index and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q <= (state == FINISH) && !cmd_abort;
            if (start_ok) begin
                base_q    <= cmd_base;
                count_q   <= cmd_count;
                idx_q     <= '0;
                aborted_q <= 1'b0;
            end else begin
                if (accept) begin
                    idx_q <= idx_q + CNT_ONE;
                end
                if (abort_ok) begin
                    aborted_q <= 1'b1;
                end
            end
        end
    end

    // registered RAM port: a write the cycle after each accept, reads during verify
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cs_q <= 1'b0;
            we_q <= 1'b0;
            if (accept) begin
                cs_q    <= 1'b1;
                we_q    <= 1'b1;
                addr_q  <= base_q + idx_q[ADDR_W-1:0];
                wdata_q <= in_data;
            end
`ifdef FIR_LOADER_VERIFY_EN
            else if (rd_req) begin
                cs_q   <= 1'b1;
                addr_q <= base_q + ridx_q[ADDR_W-1:0];
            end
`endif
        end
    end

    assign s1_address    = addr_q;
    assign s1_chipselect = cs_q;
    assign s1_write      = we_q;
    assign s1_writedata  = wdata_q;
    assign s1_byteenable = '1;
    assign s1_clken      = 1'b1;
    assign busy          = busy_int;
    assign done          = done_q;
    assign aborted       = aborted_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: directed self-checking bench for fir_coef_loader with a
// synchronous one-cycle-latency RAM model on port s1.
module tb_fir_coef_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start;
    logic        cmd_abort;
    logic [14:0] cmd_base;
    logic [15:0] cmd_count;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] s1_address;
    logic        s1_chipselect;
    logic        s1_write;
    logic [31:0] s1_writedata;
    logic [3:0]  s1_byteenable;
    logic        s1_clken;
    logic [31:0] s1_readdata;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        verify_err;

    logic [31:0] mem [0:32767];
    logic        corrupt_en;
    logic [14:0] corrupt_addr;

    logic [14:0] wr_addr [0:511];
    logic [31:0] wr_data [0:511];
    int          wr_cyc  [0:511];
    int          wr_n    = 0;
    int          done_n  = 0;
    int          cyc     = 0;
    int          wr_base;
    int          done_base;
    int          start_cyc;
    logic [31:0] words [0:127];
    logic [14:0] t2_addr [0:3];

    int n_chk  = 0;
    int n_fail = 0;

    fir_coef_loader #(.ADDR_W(15), .DATA_W(32), .RD_LAT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_start     (cmd_start),
        .cmd_abort     (cmd_abort),
        .cmd_base      (cmd_base),
        .cmd_count     (cmd_count),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .s1_address    (s1_address),
        .s1_chipselect (s1_chipselect),
        .s1_write      (s1_write),
        .s1_writedata  (s1_writedata),
        .s1_byteenable (s1_byteenable),
        .s1_clken      (s1_clken),
        .s1_readdata   (s1_readdata),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .verify_err    (verify_err)
    );

    always #5 clk = ~clk;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: write on the edge, read data valid the following cycle
    always @(posedge clk) begin
        if (s1_chipselect && s1_write) begin
            mem[s1_address] <= s1_writedata;
        end
        if (s1_chipselect && !s1_write) begin
            s1_readdata <= mem[s1_address] ^
                           ((corrupt_en && s1_address == corrupt_addr) ? 32'h1 : 32'h0);
        end
    end

    // write and done logger, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && s1_chipselect && s1_write && wr_n < 512) begin
            wr_addr[wr_n] <= s1_address;
            wr_data[wr_n] <= s1_writedata;
            wr_cyc[wr_n]  <= cyc;
            wr_n          <= wr_n + 1;
        end
        if (!rst && done) begin
            done_n <= done_n + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input logic [14:0] base, input int count, input bit toggle,
                            input int abort_after, input int restart_at,
                            input bit abort_with_start);
        int acc;
        int t;
        bit stop;
        int exp_acc;
        @(negedge clk);
        wr_base   = wr_n;
        done_base = done_n;
        cmd_start = 1'b1;
        cmd_abort = abort_with_start;
        cmd_base  = base;
        cmd_count = 16'(count);
        start_cyc = cyc;
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        acc  = 0;
        t    = 0;
        stop = (count == 0);
        while (!stop) begin
            cmd_abort = (abort_after >= 0) && (acc == abort_after);
            cmd_start = (restart_at >= 0) && (acc == restart_at);
            if (cmd_start) begin
                cmd_base  = 15'h0100;
                cmd_count = 16'd3;
            end
            in_valid = (acc < count) && (!toggle || (t % 2 == 0));
            in_data  = words[acc];
            if (in_valid && in_ready) acc++;
            if (cmd_abort || acc >= count || t >= 3000) stop = 1'b1;
            @(negedge clk);
            t++;
        end
        cmd_abort = 1'b0;
        cmd_start = 1'b0;
        in_valid  = 1'b0;
        exp_acc = (abort_after >= 0) ? abort_after + 1 : count;
        chk("accepts", acc, exp_acc);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic chk_writes(input string tag, input logic [14:0] base, input int n);
        logic [14:0] a;
        chk({tag, "_nwr"}, wr_n - wr_base, n);
        for (int i = 0; i < n; i++) begin
            a = base + 15'(i);
            chk({tag, "_addr"}, wr_addr[wr_base + i], a);
            chk({tag, "_data"}, wr_data[wr_base + i], words[i]);
        end
    endtask

    initial begin
        rst          = 1'b1;
        cmd_start    = 1'b0;
        cmd_abort    = 1'b0;
        cmd_base     = '0;
        cmd_count    = '0;
        in_data      = '0;
        in_valid     = 1'b0;
        corrupt_en   = 1'b0;
        corrupt_addr = '0;
        t2_addr[0] = 15'h7FFE;
        t2_addr[1] = 15'h7FFF;
        t2_addr[2] = 15'h0000;
        t2_addr[3] = 15'h0001;
        repeat (3) @(negedge clk);

        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_ready",  in_ready, 0);
        chk("rst_abort",  aborted, 0);
        chk("rst_verr",   verify_err, 0);
        chk("rst_cs",     s1_chipselect, 0);
        chk("rst_we",     s1_write, 0);
        chk("rst_addr",   s1_address, 0);
        chk("rst_clken",  s1_clken, 1);
        chk("rst_be",     s1_byteenable, 4'hF);
        rst = 1'b0;
        @(negedge clk);

        // 1: four words back-to-back at base 0
        for (int i = 0; i < 4; i++) words[i] = 32'(i + 1);
        run_load(15'h0000, 4, 1'b0, -1, -1, 1'b0);
        wait_done(50);
        chk("t1_done_lat", cyc - wr_cyc[wr_base + 3], 1);
        chk("t1_ready_low", in_ready, 0);
        @(negedge clk);
        chk("t1_busy_low", busy, 0);
        chk("t1_one_done", done_n - done_base, 1);
        chk_writes("t1", 15'h0000, 4);
        for (int i = 0; i < 3; i++)
            chk("t1_wr_gap", wr_cyc[wr_base + i + 1] - wr_cyc[wr_base + i], 1);

        // 2: address wrap at the top of the RAM
        for (int i = 0; i < 4; i++) words[i] = 32'hA0 + 32'(i);
        run_load(15'h7FFE, 4, 1'b0, -1, -1, 1'b0);
        wait_done(50);
        @(negedge clk);
        chk("t2_nwr", wr_n - wr_base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr", wr_addr[wr_base + i], t2_addr[i]);
            chk("t2_data", wr_data[wr_base + i], words[i]);
        end
        chk("t2_abort", aborted, 0);
        chk("t2_verr",  verify_err, 0);

        // 3: zero-length load
        run_load(15'h0010, 0, 1'b0, -1, -1, 1'b0);
        wait_done(20);
        chk("t3_done_lat", cyc - start_cyc, 2);
        @(negedge clk);
        chk("t3_nwr", wr_n - wr_base, 0);
        chk("t3_busy_low", busy, 0);

        // 4: in_valid toggling every cycle
        for (int i = 0; i < 8; i++) words[i] = 32'h1000 + 32'(i * 3);
        run_load(15'h0040, 8, 1'b1, -1, -1, 1'b0);
        wait_done(50);
        @(negedge clk);
        chk_writes("t4", 15'h0040, 8);
        for (int i = 0; i < 7; i++)
            chk("t4_wr_gap", wr_cyc[wr_base + i + 1] - wr_cyc[wr_base + i], 2);

        // 5a: abort after 10 accepts
        for (int i = 0; i < 100; i++) words[i] = 32'h5000_0000 + 32'(i);
        run_load(15'h0200, 100, 1'b0, 10, -1, 1'b0);
        repeat (6) @(negedge clk);
        chk_writes("t5a", 15'h0200, 11);
        chk("t5a_aborted", aborted, 1);
        chk("t5a_no_done", done_n - done_base, 0);
        chk("t5a_busy_low", busy, 0);

        // 5b: cmd_start while busy is ignored, then abort
        run_load(15'h0400, 100, 1'b0, 10, 5, 1'b0);
        repeat (6) @(negedge clk);
        chk_writes("t5b", 15'h0400, 11);
        chk("t5b_aborted", aborted, 1);
        chk("t5b_no_done", done_n - done_base, 0);

        // 7: start and abort in the same idle cycle - start wins, aborted cleared
        for (int i = 0; i < 2; i++) words[i] = 32'hC0DE_0000 + 32'(i);
        run_load(15'h0300, 2, 1'b0, -1, -1, 1'b1);
        wait_done(50);
        @(negedge clk);
        chk("t7_aborted", aborted, 0);
        chk("t7_one_done", done_n - done_base, 1);
        chk_writes("t7", 15'h0300, 2);

        // 8: abort in idle is ignored
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        @(negedge clk);
        chk("t8_aborted", aborted, 0);
        chk("t8_busy", busy, 0);

        // 9: reset in the middle of a load
        cmd_start = 1'b1;
        cmd_base  = 15'h0500;
        cmd_count = 16'd10;
        @(negedge clk);
        cmd_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hD000_0000 + 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t9_busy", busy, 0);
        chk("t9_ready", in_ready, 0);
        chk("t9_cs", s1_chipselect, 0);
        rst = 1'b0;
        chk("t9_mem0", mem[15'h0500], 32'hD000_0000);
        chk("t9_mem2", mem[15'h0502], 32'hD000_0002);
        @(negedge clk);

`ifdef FIR_LOADER_VERIFY_EN
        // 6: checksum read-back, clean and with one corrupted location
        for (int i = 0; i < 16; i++) words[i] = 32'h1234_0000 + 32'(i * 7);
        run_load(15'h7FF8, 16, 1'b0, -1, -1, 1'b0);
        wait_done(200);
        chk("t6_clean_verr", verify_err, 0);
        @(negedge clk);
        chk_writes("t6", 15'h7FF8, 16);
        corrupt_addr = 15'h7FFD;
        corrupt_en   = 1'b1;
        run_load(15'h7FF8, 16, 1'b0, -1, -1, 1'b0);
        wait_done(200);
        chk("t6_bad_verr", verify_err, 1);
        corrupt_en = 1'b0;
        @(negedge clk);
        chk("t6_bad_one_done", done_n - done_base, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
